// File: rtl/memory_arbiter_rr_if.sv
// ----------------------------------------------------------------------------
// memory_arbiter_rr_if
// Bundles the requester-side and memory-side buses of memory_arbiter_rr.
//
// Parameters
//   NUM_MASTERS  number of requesting masters
//   ADDR_WIDTH   request address width
//   DATA_WIDTH   read/write data width
//
// Signals (master k occupies slice [k*W +: W] of every packed bus)
//   req_valid_i / req_write_i / req_lock_i   per-master request qualifiers
//   req_addr_i / req_wr_data_i               per-master address and write data
//   req_ready_o / req_rd_data_o              per-master completion strobe and read data
//   mem_valid_o / mem_write_o                downstream request valid and write flag
//   mem_addr_o / mem_wr_data_o               downstream address and write data
//   mem_rd_data_i / mem_ready_i              downstream read data and completion strobe
//
// Modports
//   slave   the arbiter's view
//   master  the environment's view (requesters plus memory)
// ----------------------------------------------------------------------------
interface memory_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]            req_valid_i;
    logic [NUM_MASTERS-1:0]            req_write_i;
    logic [NUM_MASTERS-1:0]            req_lock_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] req_wr_data_i;
    logic [NUM_MASTERS-1:0]            req_ready_o;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] req_rd_data_o;
    logic                              mem_valid_o;
    logic                              mem_write_o;
    logic [ADDR_WIDTH-1:0]             mem_addr_o;
    logic [DATA_WIDTH-1:0]             mem_wr_data_o;
    logic [DATA_WIDTH-1:0]             mem_rd_data_i;
    logic                              mem_ready_i;

    modport slave (
        input  req_valid_i, req_write_i, req_lock_i, req_addr_i, req_wr_data_i,
        input  mem_rd_data_i, mem_ready_i,
        output req_ready_o, req_rd_data_o,
        output mem_valid_o, mem_write_o, mem_addr_o, mem_wr_data_o
    );

    modport master (
        output req_valid_i, req_write_i, req_lock_i, req_addr_i, req_wr_data_i,
        output mem_rd_data_i, mem_ready_i,
        input  req_ready_o, req_rd_data_o,
        input  mem_valid_o, mem_write_o, mem_addr_o, mem_wr_data_o
    );
endinterface

// File: rtl/memory_arbiter_rr.sv
// ----------------------------------------------------------------------------
// memory_arbiter_rr
// Arbitrates NUM_MASTERS requesters onto a single memory port. A two-state
// FSM (IDLE/BUSY) registers a one-hot grant in IDLE and forwards the granted
// master's request downstream while BUSY. Priority is rotating (ROUND_ROBIN=1)
// or fixed with lowest index highest (ROUND_ROBIN=0). A locked master keeps
// the grant across completions.
//
// Ports
//   clk_i     clock, all state changes on rising edge
//   reset_i   asynchronous active-high reset
//   bus       memory_arbiter_rr_if.slave, requester and memory buses
//   grant_o   one-hot registered grant, zero when idle
//   busy_o    high while in BUSY
// ----------------------------------------------------------------------------
module memory_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    memory_arbiter_rr_if.slave     bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   busy_o
);
    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MASTERS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;

    logic                   busy_w;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic                   win_found;
    logic [PTR_W-1:0]       scan_idx;
    logic [PTR_W-1:0]       grant_idx;
    logic                   sel_valid;
    logic                   sel_write;
    logic                   sel_lock;
    logic [ADDR_WIDTH-1:0]  addr_mux;
    logic [DATA_WIDTH-1:0]  wdata_mux;
    logic [ADDR_WIDTH-1:0]  addr_masked  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  wdata_masked [NUM_MASTERS];

    assign busy_w = (state_reg == BUSY);

    // Priority scan: start at rr_ptr (or 0 in fixed mode) and walk upward with
    // wrap; the first requester encountered wins.
    always_comb begin
        win_onehot = '0;
        win_found  = 1'b0;
        scan_idx   = (ROUND_ROBIN != 0) ? rr_ptr_reg : '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!win_found && bus.req_valid_i[scan_idx]) begin
                win_onehot[scan_idx] = 1'b1;
                win_found            = 1'b1;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + PTR_W'(1);
        end
    end

    // Index of the current grant, needed to advance the rotating pointer.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_reg[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign sel_valid = |(bus.req_valid_i & grant_reg);
    assign sel_write = |(bus.req_write_i & grant_reg);
    assign sel_lock  = |(bus.req_lock_i  & grant_reg);

    // Per-master slices are masked by the one-hot grant and OR-reduced, so the
    // downstream mux needs no decoded index.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
            assign addr_masked[gi]  = grant_reg[gi] ?
                bus.req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
            assign wdata_masked[gi] = grant_reg[gi] ?
                bus.req_wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
            assign bus.req_rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] =
                (busy_w && grant_reg[gi]) ? bus.mem_rd_data_i : '0;
        end
    endgenerate

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_mux  = addr_mux  | addr_masked[i];
            wdata_mux = wdata_mux | wdata_masked[i];
        end
    end

    // Next-state logic.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next = BUSY;
                    grant_next = win_onehot;
                end
            end
            BUSY: begin
                if (bus.mem_ready_i) begin
                    // A locked master keeps the grant and the pointer stays put.
                    if (!sel_lock) begin
                        state_next  = IDLE;
                        grant_next  = '0;
                        rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
                    end
                end else if (!sel_valid) begin
                    // Abort: release without advancing so the same master can
                    // win again.
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign grant_o           = grant_reg;
    assign busy_o            = busy_w;
    assign bus.mem_valid_o   = busy_w & sel_valid;
    assign bus.mem_write_o   = busy_w & sel_write;
    assign bus.mem_addr_o    = busy_w ? addr_mux  : '0;
    assign bus.mem_wr_data_o = busy_w ? wdata_mux : '0;
    assign bus.req_ready_o   = (busy_w && bus.mem_ready_i) ? grant_reg : '0;

endmodule
